// File: rtl/pipe_stage_regs.sv
// PC, IF/ID, ID/EX and EX/MEM pipeline registers with stall/flush control.
// Optional stall/flush statistics counters enabled by macro PIPE_STATS_EN.
module pipe_stage_regs #(
  parameter int          CTRL_W   = 10,
  parameter logic [31:0] PC_RESET = 32'h0000_0000
`ifdef PIPE_STATS_EN
  ,parameter int         CNT_W    = 16
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       pc_next_i,
  output logic [31:0]       pc_o,
  input  logic              PCWrite,
  input  logic              write_ifid,
  input  logic              flush_ifid,
  input  logic              flush_idex,
  input  logic              flush_exmem,
  input  logic [31:0]       if_instr_i,
  input  logic [31:0]       if_pc4_i,
  output logic [31:0]       ifid_instr_o,
  output logic [31:0]       ifid_pc4_o,
  output logic              ifid_valid_o,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic [4:0]        id_rs_i,
  input  logic [4:0]        id_rt_i,
  input  logic [4:0]        id_rd_i,
  output logic [CTRL_W-1:0] idex_ctrl_o,
  output logic [4:0]        rs_idex_o,
  output logic [4:0]        rt_idex_o,
  output logic [4:0]        rd_idex_o,
  output logic              MemRead_idex,
  output logic              idex_valid_o,
  input  logic [4:0]        ex_wreg_i,
  output logic [4:0]        exmem_ctrl_o,
  output logic [4:0]        exmem_wreg_o,
  output logic              exmem_valid_o
`ifdef PIPE_STATS_EN
  ,output logic [CNT_W-1:0] stall_cnt_o
  ,output logic [CNT_W-1:0] flush_cnt_o
`endif
);

  logic [31:0]       r_pc;
  logic [31:0]       r_ifid_instr;
  logic [31:0]       r_ifid_pc4;
  logic              r_ifid_valid;
  logic [CTRL_W-1:0] r_idex_ctrl;
  logic [4:0]        r_idex_rs;
  logic [4:0]        r_idex_rt;
  logic [4:0]        r_idex_rd;
  logic              r_idex_valid;
  logic [4:0]        r_exmem_ctrl;
  logic [4:0]        r_exmem_wreg;
  logic              r_exmem_valid;

  // PC: load next PC when enabled, otherwise hold
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pc <= PC_RESET;
    end else if (PCWrite) begin
      r_pc <= pc_next_i;
    end
  end

  // IF/ID: flush beats hold, hold beats load
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ifid_instr <= '0;
      r_ifid_pc4   <= '0;
      r_ifid_valid <= 1'b0;
    end else if (flush_ifid) begin
      r_ifid_instr <= '0;
      r_ifid_pc4   <= '0;
      r_ifid_valid <= 1'b0;
    end else if (write_ifid) begin
      r_ifid_instr <= if_instr_i;
      r_ifid_pc4   <= if_pc4_i;
      r_ifid_valid <= 1'b1;
    end
  end

  // ID/EX: bubble on flush, else advance carrying IF/ID validity
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_idex_ctrl  <= '0;
      r_idex_rs    <= '0;
      r_idex_rt    <= '0;
      r_idex_rd    <= '0;
      r_idex_valid <= 1'b0;
    end else if (flush_idex) begin
      r_idex_ctrl  <= '0;
      r_idex_rs    <= '0;
      r_idex_rt    <= '0;
      r_idex_rd    <= '0;
      r_idex_valid <= 1'b0;
    end else begin
      r_idex_ctrl  <= id_ctrl_i;
      r_idex_rs    <= id_rs_i;
      r_idex_rt    <= id_rt_i;
      r_idex_rd    <= id_rd_i;
      r_idex_valid <= r_ifid_valid;
    end
  end

  // EX/MEM: bubble on flush, else take MEM/WB controls from ID/EX
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_exmem_ctrl  <= '0;
      r_exmem_wreg  <= '0;
      r_exmem_valid <= 1'b0;
    end else if (flush_exmem) begin
      r_exmem_ctrl  <= '0;
      r_exmem_wreg  <= '0;
      r_exmem_valid <= 1'b0;
    end else begin
      r_exmem_ctrl  <= r_idex_ctrl[4:0];
      r_exmem_wreg  <= ex_wreg_i;
      r_exmem_valid <= r_idex_valid;
    end
  end

`ifdef PIPE_STATS_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Saturating counts of PC stalls and front-end flushes
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!PCWrite && !flush_ifid && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (flush_ifid && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`endif

  assign pc_o          = r_pc;
  assign ifid_instr_o  = r_ifid_instr;
  assign ifid_pc4_o    = r_ifid_pc4;
  assign ifid_valid_o  = r_ifid_valid;
  assign idex_ctrl_o   = r_idex_ctrl;
  assign rs_idex_o     = r_idex_rs;
  assign rt_idex_o     = r_idex_rt;
  assign rd_idex_o     = r_idex_rd;
  assign idex_valid_o  = r_idex_valid;
  assign MemRead_idex  = r_idex_ctrl[2];
  assign exmem_ctrl_o  = r_exmem_ctrl;
  assign exmem_wreg_o  = r_exmem_wreg;
  assign exmem_valid_o = r_exmem_valid;

endmodule

// File: doc/pipe_stage_regs.md
Name: pipe_stage_regs

Overview:
Pipeline-register bank for the 5-stage MIPS core: the PC, IF/ID, ID/EX and EX/MEM registers.
- Consumes the stall/flush controls from the hazard detect unit: PCWrite, write_ifid, flush_ifid, flush_idex, flush_exmem.
- Produces the ID/EX-stage state that the hazard unit reads back: MemRead_idex, rt_idex.
- Sits between the stage datapaths and owns all sequential stall and bubble behaviour.

Parameters:
CTRL_W, 10, width of the ID-stage control bundle. Bit map: [0] RegWrite, [1] MemtoReg, [2] MemRead, [3] MemWrite, [4] Branch; bits [CTRL_W-1:5] are EX-only controls.
PC_RESET, 32'h0000_0000, PC value loaded on reset.
CNT_W, 16, width of the statistics counters (optional feature only).

Ports:
clk_i  in  1  clock; all registers update on the rising edge
rst_i  in  1  asynchronous, active-low reset
pc_next_i  in  32  next-PC value (PC+4 or branch target), selected by the datapath
pc_o  out  32  current PC
PCWrite  in  1  1 = load pc_next_i into the PC
write_ifid  in  1  1 = load the IF/ID register
flush_ifid  in  1  1 = clear IF/ID
flush_idex  in  1  1 = load a bubble into ID/EX
flush_exmem  in  1  1 = load a bubble into EX/MEM
if_instr_i  in  32  fetched instruction
if_pc4_i  in  32  PC+4 from the IF stage
ifid_instr_o  out  32  IF/ID instruction
ifid_pc4_o  out  32  IF/ID PC+4
ifid_valid_o  out  1  IF/ID holds a real instruction
id_ctrl_i  in  CTRL_W  decoded control bundle from the ID stage
id_rs_i, id_rt_i, id_rd_i  in  5 each  register specifiers from the ID stage
idex_ctrl_o  out  CTRL_W  ID/EX control bundle
rs_idex_o, rt_idex_o, rd_idex_o  out  5 each  ID/EX register specifiers
MemRead_idex  out  1  equal to idex_ctrl_o[2]
idex_valid_o  out  1  ID/EX holds a real instruction
ex_wreg_i  in  5  write-register number selected in the EX stage
exmem_ctrl_o  out  5  EX/MEM control bits; receives idex_ctrl_o[4:0]
exmem_wreg_o  out  5  EX/MEM write-register number
exmem_valid_o  out  1  EX/MEM holds a real instruction

Behaviour:
- Reset (rst_i=0, asynchronous): every output register goes to 0, except pc_o, which goes to PC_RESET. Reset has priority over every other input, including mid-stall and mid-flush. The first update happens on the first rising edge after rst_i rises.
- Latency: one cycle per stage register. No combinational path from any input to any output, except MemRead_idex, which is a wire from idex_ctrl_o[2].
- PC register: PCWrite=1 loads pc_next_i; PCWrite=0 holds pc_o.
- IF/ID register, priority flush > hold > load:
  - flush_ifid=1: instr=0, pc4=0, valid=0. Applies even when write_ifid=1.
  - else write_ifid=0: hold all IF/ID fields.
  - else: load if_instr_i and if_pc4_i, valid=1.
- ID/EX register:
  - flush_idex=1: ctrl=0, rs/rt/rd=0, valid=0 (bubble). A bubble with ctrl=0 never asserts MemRead_idex, so a load-use stall lasts exactly one cycle.
  - else: load id_ctrl_i, the specifiers, and valid=ifid_valid_o. An instruction leaving a flushed IF/ID therefore carries valid=0. Its ctrl is still taken from id_ctrl_i; the decoder yields ctrl=0 for instruction word 0.
- EX/MEM register:
  - flush_exmem=1: ctrl=0, wreg=0, valid=0.
  - else: load idex_ctrl_o[4:0], ex_wreg_i, and valid=idex_valid_o.
- Combined control patterns from the hazard unit:
  - Branch (11111): PC loads the target; IF/ID, ID/EX and EX/MEM all become bubbles in the same edge.
  - Load-use (00010): PC and IF/ID hold; ID/EX takes a bubble; EX/MEM advances normally.
  - Normal (11000): every register advances.
- Any other control combination is applied bit-by-bit with the priorities above. No illegal-state checking.
- Sizing: CTRL_W values below 5 are unsupported.

Optional Feature:
Macro PIPE_STATS_EN.
- Defined: adds outputs stall_cnt_o and flush_cnt_o, each CNT_W bits, both reset to 0.
  - stall_cnt_o increments on each edge where PCWrite=0 and flush_ifid=0.
  - flush_cnt_o increments on each edge where flush_ifid=1.
  - Both saturate at all-ones and do not wrap. They are cleared only by reset.
- Not defined: neither port nor any counter logic exists. All other behaviour is identical.

Test Plan:
- Reset mid-run: rst_i low asynchronously while PCWrite=1 and the stages hold data -> without waiting for a clock edge, pc_o=0, all valids 0, all ctrl 0, MemRead_idex=0.
- Normal flow: controls 11000, if_instr_i=32'h8C220004, pc_next_i=4 -> after edge 1, ifid_instr_o=32'h8C220004 and valid=1. After edge 2, idex_ctrl_o=id_ctrl_i and idex_valid_o=1.
- Load-use stall: idex_ctrl[2]=1, then controls 00010 for one cycle -> pc_o and ifid_instr_o unchanged, idex_ctrl_o=0 and MemRead_idex=0 after the edge. With 11000 on the next edge, all stages advance.
- Branch flush: controls 11111 with pc_next_i=32'h40 -> pc_o=32'h40. ifid, idex and exmem valids and ctrl are all 0 after one edge.
- Flush beats write: write_ifid=1 and flush_ifid=1 -> ifid_instr_o=0, ifid_valid_o=0.
- PIPE_STATS_EN with CNT_W=4: 20 stall cycles -> stall_cnt_o=4'hF. Then 3 branch flushes -> flush_cnt_o=3 and stall_cnt_o still 4'hF.
